// File: rtl/mips20_pipeline.sv
// mips20_pipeline: 5-stage in-order 32-bit MIPS-style core (IF/ID/EX/MEM/WB)
// with one unified word-addressed memory and no interlocks or forwarding.
module mips20_pipeline #(
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic        clk1,
    input  logic        rst,
    output logic [31:0] pc_out,
    output logic [31:0] alu_result,
    output logic        halted_out,
    output logic [31:0] debug_operand1,
    output logic [31:0] debug_operand2
);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    typedef enum logic [2:0] {
        T_NOP, T_RR, T_RM, T_LOAD, T_STORE, T_BRANCH, T_HALT
    } op_type_t;

    // Architectural storage, named for hierarchical access.
    logic [31:0] Mem [0:MEM_DEPTH-1];
    logic [31:0] Reg [0:31];

    // Fetch state
    logic [31:0] pc;
    logic        halt_seen;
    logic [31:0] if_id_ir, if_id_npc;

    // ID/EX
    logic [5:0]  id_ex_op;
    op_type_t    id_ex_type;
    logic [4:0]  id_ex_dst;
    logic [31:0] id_ex_npc, id_ex_a, id_ex_b, id_ex_imm;

    // EX/MEM
    op_type_t    ex_mem_type;
    logic [4:0]  ex_mem_dst;
    logic [31:0] ex_mem_alu, ex_mem_b;

    // MEM/WB
    op_type_t    mem_wb_type;
    logic [4:0]  mem_wb_dst;
    logic [31:0] mem_wb_alu, mem_wb_lmd;
    logic        halted;

    // Decode fields
    logic [5:0]  id_op;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_imm, id_a, id_b;
    op_type_t    id_type;
    logic [4:0]  id_dst;

    assign id_op  = if_id_ir[31:26];
    assign id_rs  = if_id_ir[25:21];
    assign id_rt  = if_id_ir[20:16];
    assign id_rd  = if_id_ir[15:11];
    assign id_imm = {{16{if_id_ir[15]}}, if_id_ir[15:0]};

    // Classify the instruction in ID and read its operands (R0 reads as zero).
    always_comb begin
        id_type = T_NOP;
        id_dst  = 5'd0;
        case (id_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
                id_type = T_RR;
                id_dst  = id_rd;
            end
            OP_ADDI, OP_SUBI, OP_SLTI: begin
                id_type = T_RM;
                id_dst  = id_rt;
            end
            OP_LW: begin
                id_type = T_LOAD;
                id_dst  = id_rt;
            end
            OP_SW:             id_type = T_STORE;
            OP_BNEQZ, OP_BEQZ: id_type = T_BRANCH;
            OP_HLT:            id_type = T_HALT;
            default:           id_type = T_NOP;
        endcase
        id_a = (id_rs == 5'd0) ? 32'd0 : Reg[id_rs];
        id_b = (id_rt == 5'd0) ? 32'd0 : Reg[id_rt];
    end

    // Execute: ALU result, memory address or branch target, plus branch decision.
    logic [31:0] ex_alu;
    logic        ex_taken;

    always_comb begin
        ex_alu   = 32'd0;
        ex_taken = 1'b0;
        case (id_ex_type)
            T_RR: begin
                case (id_ex_op)
                    OP_ADD:  ex_alu = id_ex_a + id_ex_b;
                    OP_SUB:  ex_alu = id_ex_a - id_ex_b;
                    OP_AND:  ex_alu = id_ex_a & id_ex_b;
                    OP_OR:   ex_alu = id_ex_a | id_ex_b;
                    OP_SLT:  ex_alu = {31'd0, $signed(id_ex_a) < $signed(id_ex_b)};
                    OP_MUL:  ex_alu = id_ex_a * id_ex_b;
                    default: ex_alu = 32'd0;
                endcase
            end
            T_RM: begin
                case (id_ex_op)
                    OP_ADDI: ex_alu = id_ex_a + id_ex_imm;
                    OP_SUBI: ex_alu = id_ex_a - id_ex_imm;
                    OP_SLTI: ex_alu = {31'd0, $signed(id_ex_a) < $signed(id_ex_imm)};
                    default: ex_alu = 32'd0;
                endcase
            end
            T_LOAD, T_STORE: ex_alu = id_ex_a + id_ex_imm;
            T_BRANCH: begin
                ex_alu   = id_ex_npc + id_ex_imm;
                ex_taken = (id_ex_op == OP_BEQZ) ? (id_ex_a == 32'd0) : (id_ex_a != 32'd0);
            end
            default: ex_alu = 32'd0;
        endcase
    end

    // Fetch: a taken branch redirects and squashes; a decoded HLT freezes PC and bubbles IF.
    always_ff @(posedge clk1) begin
        if (rst) begin
            pc        <= 32'd0;
            halt_seen <= 1'b0;
            if_id_ir  <= 32'd0;
            if_id_npc <= 32'd0;
        end else if (ex_taken) begin
            pc        <= ex_alu;
            if_id_ir  <= 32'd0;
            if_id_npc <= 32'd0;
        end else if (halt_seen || id_type == T_HALT) begin
            halt_seen <= 1'b1;
            if_id_ir  <= 32'd0;
            if_id_npc <= 32'd0;
        end else begin
            pc        <= pc + 32'd1;
            if_id_ir  <= Mem[pc[ADDR_W-1:0]];
            if_id_npc <= pc + 32'd1;
        end
    end

    // ID/EX register; a taken branch turns the instruction behind it into a bubble.
    always_ff @(posedge clk1) begin
        if (rst || ex_taken) begin
            id_ex_op   <= 6'd0;
            id_ex_type <= T_NOP;
            id_ex_dst  <= 5'd0;
            id_ex_npc  <= 32'd0;
            id_ex_a    <= 32'd0;
            id_ex_b    <= 32'd0;
            id_ex_imm  <= 32'd0;
        end else begin
            id_ex_op   <= id_op;
            id_ex_type <= id_type;
            id_ex_dst  <= id_dst;
            id_ex_npc  <= if_id_npc;
            id_ex_a    <= id_a;
            id_ex_b    <= id_b;
            id_ex_imm  <= id_imm;
        end
    end

    // EX/MEM register.
    always_ff @(posedge clk1) begin
        if (rst) begin
            ex_mem_type <= T_NOP;
            ex_mem_dst  <= 5'd0;
            ex_mem_alu  <= 32'd0;
            ex_mem_b    <= 32'd0;
        end else begin
            ex_mem_type <= id_ex_type;
            ex_mem_dst  <= id_ex_dst;
            ex_mem_alu  <= ex_alu;
            ex_mem_b    <= id_ex_b;
        end
    end

    // MEM/WB register with the load data read from memory.
    always_ff @(posedge clk1) begin
        if (rst) begin
            mem_wb_type <= T_NOP;
            mem_wb_dst  <= 5'd0;
            mem_wb_alu  <= 32'd0;
            mem_wb_lmd  <= 32'd0;
        end else begin
            mem_wb_type <= ex_mem_type;
            mem_wb_dst  <= ex_mem_dst;
            mem_wb_alu  <= ex_mem_alu;
            mem_wb_lmd  <= Mem[ex_mem_alu[ADDR_W-1:0]];
        end
    end

    // Store port; memory is never reset so contents survive a core reset.
    always_ff @(posedge clk1) begin
        if (!rst && !halted && ex_mem_type == T_STORE)
            Mem[ex_mem_alu[ADDR_W-1:0]] <= ex_mem_b;
    end

    // Write-back and halt latch; nothing retires once halted.
    always_ff @(posedge clk1) begin
        if (rst) begin
            halted <= 1'b0;
            for (int i = 0; i < 32; i++) Reg[i] <= 32'd0;
        end else if (!halted) begin
            if (mem_wb_type == T_HALT)
                halted <= 1'b1;
            else if (mem_wb_dst != 5'd0 && (mem_wb_type == T_RR || mem_wb_type == T_RM))
                Reg[mem_wb_dst] <= mem_wb_alu;
            else if (mem_wb_dst != 5'd0 && mem_wb_type == T_LOAD)
                Reg[mem_wb_dst] <= mem_wb_lmd;
        end
    end

    assign pc_out         = pc;
    assign alu_result     = ex_mem_alu;
    assign halted_out     = halted;
    assign debug_operand1 = id_ex_a;
    assign debug_operand2 = id_ex_b;

endmodule

// File: tb/tb_mips20_pipeline.sv
// Directed self-checking bench for mips20_pipeline.
module tb_mips20_pipeline;

    logic        clk1 = 1'b0;
    logic        rst  = 1'b1;
    logic [31:0] pc_out, alu_result, debug_operand1, debug_operand2;
    logic        halted_out;

    int n_cmp = 0;
    int n_bad = 0;

    mips20_pipeline #(.MEM_DEPTH(1024), .ADDR_W(10)) dut (
        .clk1(clk1), .rst(rst), .pc_out(pc_out), .alu_result(alu_result),
        .halted_out(halted_out), .debug_operand1(debug_operand1),
        .debug_operand2(debug_operand2)
    );

    always #5 clk1 = ~clk1;

    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b000010,
                           OR_ = 6'b000011, SLT = 6'b000100, MUL = 6'b000101,
                           LW = 6'b001000, SW = 6'b001001, ADDI = 6'b001010,
                           SUBI = 6'b001011, SLTI = 6'b001100, BNEQZ = 6'b001101,
                           BEQZ = 6'b001110, HLT = 6'b111111;

    function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Hold reset, wipe the low program/data area.
    task automatic load_begin();
        rst = 1'b1;
        @(posedge clk1); #1;
        for (int i = 0; i < 256; i++) dut.Mem[i] <= 32'd0;
    endtask

    task automatic put(input int a, input logic [31:0] w);
        dut.Mem[a] <= w;
    endtask

    task automatic release_rst();
        @(negedge clk1);
        rst = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk1); #1; end
    endtask

    // Bounded wait for halted_out; returns edges counted.
    task automatic wait_halt(input string name, output int cnt);
        cnt = 0;
        while (halted_out !== 1'b1 && cnt < 400) begin
            @(posedge clk1); #1;
            cnt++;
        end
        n_cmp++;
        if (halted_out !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_halt_timeout: halted_out=%b required 1", name, halted_out);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        n_cmp++; if (pc_out !== 32'd0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", pc_out); end
        n_cmp++; if (alu_result !== 32'd0) begin n_bad++; $display("FAIL reset_alu: got %h want 0", alu_result); end
        n_cmp++; if (halted_out !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", halted_out); end
        n_cmp++; if (debug_operand1 !== 32'd0) begin n_bad++; $display("FAIL reset_op1: got %h want 0", debug_operand1); end
        n_cmp++; if (debug_operand2 !== 32'd0) begin n_bad++; $display("FAIL reset_op2: got %h want 0", debug_operand2); end
        n_cmp++; if (dut.Reg[5] !== 32'd0) begin n_bad++; $display("FAIL reset_reg5: got %h want 0", dut.Reg[5]); end
    endtask

    task automatic load_mem_prog();
        load_begin();
        put(0,  32'h28010064);
        put(4,  32'h280215B3);
        put(8,  32'h24220000);
        put(12, 32'h20230000);
        put(16, 32'hFC000000);
    endtask

    task automatic test_memory();
        int cnt;
        load_mem_prog();
        release_rst();
        step(10);   // SW (addr 8) now sits in ID/EX
        n_cmp++; if (debug_operand1 !== 32'd100) begin n_bad++; $display("FAIL mem_sw_op1: got %0d want 100", debug_operand1); end
        n_cmp++; if (debug_operand2 !== 32'd5555) begin n_bad++; $display("FAIL mem_sw_op2: got %0d want 5555", debug_operand2); end
        step(1);
        n_cmp++; if (alu_result !== 32'd100) begin n_bad++; $display("FAIL mem_sw_addr: got %0d want 100", alu_result); end
        wait_halt("mem", cnt);
        n_cmp++; if (dut.Mem[100] !== 32'd5555) begin n_bad++; $display("FAIL mem_store: got %0d want 5555", dut.Mem[100]); end
        n_cmp++; if (dut.Reg[3] !== 32'd5555) begin n_bad++; $display("FAIL mem_load: got %0d want 5555", dut.Reg[3]); end
    endtask

    task automatic test_alu();
        int cnt;
        logic [31:0] prog [0:12];
        logic [4:0]  dreg [0:9];
        logic [31:0] want [0:9];
        prog[0]  = ri(ADDI, 5'd1, 5'd0, 16'd7);
        prog[1]  = ri(ADDI, 5'd2, 5'd0, 16'd3);
        prog[2]  = rr(ADD,  5'd3, 5'd1, 5'd2);
        prog[3]  = rr(SUB,  5'd4, 5'd1, 5'd2);
        prog[4]  = rr(AND_, 5'd5, 5'd1, 5'd2);
        prog[5]  = rr(OR_,  5'd6, 5'd1, 5'd2);
        prog[6]  = rr(MUL,  5'd7, 5'd1, 5'd2);
        prog[7]  = rr(SLT,  5'd8, 5'd1, 5'd2);
        prog[8]  = ri(SLTI, 5'd9, 5'd2, 16'd5);
        prog[9]  = ri(SUBI, 5'd1, 5'd1, 16'd10);
        prog[10] = rr(SLT,  5'd10, 5'd1, 5'd2);
        prog[11] = ri(SLTI, 5'd11, 5'd1, 16'hFFFC);
        prog[12] = {HLT, 26'd0};
        dreg = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd1, 5'd10, 5'd11};
        want = '{32'd10, 32'd4, 32'd3, 32'd7, 32'd21, 32'd0, 32'd1, 32'hFFFFFFFD, 32'd1, 32'd0};
        load_begin();
        for (int i = 0; i < 13; i++) put(4 * i, prog[i]);
        release_rst();
        wait_halt("alu", cnt);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (dut.Reg[dreg[i]] !== want[i]) begin
                n_bad++;
                $display("FAIL alu_r%0d: got %h want %h", dreg[i], dut.Reg[dreg[i]], want[i]);
            end
        end
    endtask

    task automatic test_branch();
        int cnt;
        logic [5:0]  bop [0:3];
        logic [15:0] r1v [0:3];
        logic [31:0] r5w [0:3];
        bop = '{BEQZ, BNEQZ, BNEQZ, BEQZ};
        r1v = '{16'd0, 16'd0, 16'd5, 16'd5};
        r5w = '{32'd0, 32'd3, 32'd0, 32'd3};
        for (int k = 0; k < 4; k++) begin
            load_begin();
            put(0, ri(ADDI, 5'd1, 5'd0, r1v[k]));
            put(4, ri(bop[k], 5'd0, 5'd1, 16'd3));
            put(5, ri(ADDI, 5'd5, 5'd0, 16'd1));
            put(6, ri(ADDI, 5'd5, 5'd0, 16'd2));
            put(7, ri(ADDI, 5'd5, 5'd0, 16'd3));
            put(8, ri(ADDI, 5'd7, 5'd0, 16'd77));
            put(9, {HLT, 26'd0});
            release_rst();
            wait_halt("br", cnt);
            n_cmp++; if (dut.Reg[5] !== r5w[k]) begin n_bad++; $display("FAIL br%0d_r5: got %0d want %0d", k, dut.Reg[5], r5w[k]); end
            n_cmp++; if (dut.Reg[7] !== 32'd77) begin n_bad++; $display("FAIL br%0d_r7: got %0d want 77", k, dut.Reg[7]); end
            n_cmp++; if (pc_out !== 32'd10) begin n_bad++; $display("FAIL br%0d_pc: got %0d want 10", k, pc_out); end
        end
    endtask

    task automatic test_r0();
        int cnt;
        load_begin();
        put(0, ri(ADDI, 5'd0, 5'd0, 16'd9));
        put(4, rr(ADD, 5'd6, 5'd0, 5'd0));
        put(5, {HLT, 26'd0});
        release_rst();
        wait_halt("r0", cnt);
        n_cmp++; if (dut.Reg[6] !== 32'd0) begin n_bad++; $display("FAIL r0_r6: got %0d want 0", dut.Reg[6]); end
        n_cmp++; if (dut.Reg[0] !== 32'd0) begin n_bad++; $display("FAIL r0_r0: got %0d want 0", dut.Reg[0]); end
    endtask

    task automatic test_halt_freeze();
        int cnt;
        load_begin();
        put(0, ri(ADDI, 5'd1, 5'd0, 16'd100));
        put(4, ri(ADDI, 5'd2, 5'd0, 16'd42));
        put(8, {HLT, 26'd0});
        put(9, ri(SW, 5'd2, 5'd1, 16'd0));
        put(100, 32'hDEADBEEF);
        release_rst();
        wait_halt("hf", cnt);
        // HLT fetched on edge 9 retires on edge 13
        n_cmp++; if (cnt !== 13) begin n_bad++; $display("FAIL hf_latency: got %0d edges want 13", cnt); end
        for (int i = 0; i < 12; i++) begin
            step(1);
            n_cmp++; if (pc_out !== 32'd9) begin n_bad++; $display("FAIL hf_pc%0d: got %0d want 9", i, pc_out); end
            n_cmp++; if (halted_out !== 1'b1) begin n_bad++; $display("FAIL hf_halted%0d: got %b want 1", i, halted_out); end
        end
        n_cmp++; if (dut.Mem[100] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL hf_mem: got %h want deadbeef", dut.Mem[100]); end
        n_cmp++; if (dut.Reg[2] !== 32'd42) begin n_bad++; $display("FAIL hf_r2: got %0d want 42", dut.Reg[2]); end
    endtask

    task automatic test_reset_mid();
        int cnt;
        load_mem_prog();
        release_rst();
        step(14);
        @(negedge clk1);
        rst = 1'b1;
        @(posedge clk1); #1;
        n_cmp++; if (pc_out !== 32'd0) begin n_bad++; $display("FAIL rm_pc: got %0d want 0", pc_out); end
        n_cmp++; if (halted_out !== 1'b0) begin n_bad++; $display("FAIL rm_halted: got %b want 0", halted_out); end
        n_cmp++; if (alu_result !== 32'd0) begin n_bad++; $display("FAIL rm_alu: got %h want 0", alu_result); end
        n_cmp++; if (dut.Reg[1] !== 32'd0) begin n_bad++; $display("FAIL rm_r1: got %0d want 0", dut.Reg[1]); end
        n_cmp++; if (dut.Mem[100] !== 32'd5555) begin n_bad++; $display("FAIL rm_mem_kept: got %0d want 5555", dut.Mem[100]); end
        dut.Mem[100] <= 32'd0;
        release_rst();
        wait_halt("rm", cnt);
        n_cmp++; if (dut.Mem[100] !== 32'd5555) begin n_bad++; $display("FAIL rm_store: got %0d want 5555", dut.Mem[100]); end
        n_cmp++; if (dut.Reg[3] !== 32'd5555) begin n_bad++; $display("FAIL rm_load: got %0d want 5555", dut.Reg[3]); end
        n_cmp++; if (dut.Reg[1] !== 32'd100) begin n_bad++; $display("FAIL rm_r1_rerun: got %0d want 100", dut.Reg[1]); end
    endtask

    initial begin
        test_reset();
        test_memory();
        test_alu();
        test_branch();
        test_r0();
        test_halt_freeze();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
